// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and issues one imem read at a time
// over a req/ack handshake. The fetched word is held for decode behind a
// valid/ready handshake. Branch-unit redirects can arrive in any state.
// Optional watchdog: define FETCH_TIMEOUT_EN to enable the sticky
// fetch_timeout flag; otherwise fetch_timeout is tied low.
module instr_fetch_unit #(
  parameter int                 ADDR_W         = 32,
  parameter int                 INSTR_W        = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC       = '0,
  parameter int                 PC_STEP        = 4,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus,
  output logic               fetch_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic              issue;   // a new request is being launched (entering REQ)
  logic              load;    // accepted read data goes into the instruction register

  assign imem_req    = (state == S_REQ) || (state == S_DROP);
  assign imem_addr   = req_addr;
  assign instr_valid = (state == S_HOLD);
  assign opcode      = instr[31:26];

  // Next-state and PC/request-address selection; redirect always wins.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    issue        = 1'b0;
    load         = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt    = S_REQ;
        req_addr_nxt = pc;
        issue        = 1'b1;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (imem_ack) begin
            // Returned data belongs to the squashed path; restart at target.
            req_addr_nxt = redirect_pc;
            issue        = 1'b1;
          end else begin
            // Old request must still complete before the new one can go out.
            state_nxt = S_DROP;
          end
        end else if (imem_ack) begin
          load      = 1'b1;
          pc_nxt    = req_addr + STEP;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          // Held instruction is squashed even if decode accepted it this cycle.
          pc_nxt       = redirect_pc;
          req_addr_nxt = redirect_pc;
          issue        = 1'b1;
          state_nxt    = S_REQ;
        end else if (instr_ready) begin
          req_addr_nxt = pc;
          issue        = 1'b1;
          state_nxt    = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_nxt = redirect_pc;
        if (imem_ack) begin
          req_addr_nxt = redirect_valid ? redirect_pc : pc;
          issue        = 1'b1;
          state_nxt    = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, PC and outstanding request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  // Instruction register with its address and link value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
      pc_plus  <= STEP;
    end else if (load) begin
      instr    <= imem_rdata;
      instr_pc <= req_addr;
      pc_plus  <= req_addr + STEP;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
  logic             wd_clr;

  // Counting restarts whenever a request (or drop phase) begins.
  assign wd_clr = issue || (state == S_REQ && state_nxt == S_DROP);

  // Watchdog count of request cycles without ack; saturates at the limit.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (wd_clr)
      wd_cnt_nxt = '0;
    else if (imem_req && !imem_ack && wd_cnt != CNT_W'(TIMEOUT_CYCLES))
      wd_cnt_nxt = wd_cnt + 1'b1;
  end

  // Counter register and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      if (wd_cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) fetch_timeout <= 1'b1;
    end
  end
`else
  // Watchdog absent: flag is constant low (TIMEOUT_CYCLES is non-negative).
  assign fetch_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage of the RISC core; sits directly upstream of the main control decoder.
- Owns the PC and issues one instruction-memory read at a time over a req/ack handshake.
- Holds the fetched word in an instruction register and presents it, with its opcode field, to decode over a valid/ready handshake.
- Accepts PC redirects from the branch unit, including branch and call/return targets.

Parameters:
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value after reset
PC_STEP, 4, PC increment per sequential fetch
TIMEOUT_CYCLES, 16, watchdog limit (optional feature only)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  read request; held high until imem_ack
imem_addr  out  ADDR_W  read address; stable while imem_req high
imem_ack  in  1  one-cycle pulse, valid only while imem_req high; imem_rdata valid same cycle
imem_rdata  in  INSTR_W  read data
redirect_valid  in  1  one-cycle pulse: load new PC
redirect_pc  in  ADDR_W  redirect target
instr_valid  out  1  instr/opcode/instr_pc valid for decode
instr_ready  in  1  decode accepts instruction
instr  out  INSTR_W  instruction register
opcode  out  6  instr[31:26], combinational from instruction register, feeds control decoder
instr_pc  out  ADDR_W  address of held instruction
pc_plus  out  ADDR_W  instr_pc + PC_STEP (link value for call)
fetch_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; pc = RESET_PC.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0, pc_plus = PC_STEP, fetch_timeout = 0.
- imem_req is high exactly in states REQ and DROP.
- A separate req_addr register drives imem_addr and updates only when entering REQ.
- IDLE -> REQ unconditionally on the first edge after reset release.
- REQ, no ack: hold request.
- REQ, ack:
  - Latch instr = imem_rdata, instr_pc = req_addr, pc = req_addr + PC_STEP.
  - Go to HOLD; instr_valid is high the next cycle. Minimum memory latency is 1 cycle (ack in the first req cycle).
- HOLD:
  - instr_valid high; instr, opcode and instr_pc stable while instr_ready is low.
  - On instr_valid && instr_ready: go to REQ with req_addr = pc.
  - Throughput is at most one instruction per 2 cycles.
- Redirect rules (redirect_valid has highest priority):
  - REQ, no ack same cycle: pc = redirect_pc; go to DROP. The outstanding request stays up at the old address until acked.
  - REQ, ack same cycle: data discarded; pc = redirect_pc; go to REQ at redirect_pc.
  - DROP: on ack, discard data and go to REQ at pc. A redirect while in DROP only updates pc.
  - HOLD: instr_valid drops next cycle; the held instruction is discarded even if instr_ready was high in the same cycle. That handshake counts as not having occurred, and decode squashes under the same rule. Go to REQ at redirect_pc.
- Arithmetic:
  - All PC sums are modulo 2^ADDR_W; 0xFFFFFFFC + 4 wraps to 0x00000000.
  - pc_plus = instr_pc + PC_STEP, registered with instr_pc.
- Only one request outstanding. An ack outside REQ/DROP is ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entering REQ/DROP and increments each cycle imem_req is high without ack.
  - When the counter reaches TIMEOUT_CYCLES, fetch_timeout goes high and stays high (sticky) until rst_n.
  - Fetch keeps waiting and otherwise behaves normally.
- Undefined: no counter; fetch_timeout tied 0.

Test Plan:
- Reset release, RESET_PC=0, ack in first req cycle with 0x14220000 -> imem_req 1 cycle after release, addr 0; instr_valid, opcode 6'b000101, instr_pc 0, pc_plus 4; next imem_addr 4.
- instr_ready low 5 cycles in HOLD -> instr_valid stays 1, instr unchanged, imem_req 0; accept -> next req at next address.
- Redirect to 0x40 in HOLD with instr_ready high same cycle -> instr_valid 0 next cycle, next imem_addr 0x40, instr_pc 0x40 after ack.
- Redirect to 0x80 while request at 0x8 pending, ack after 3 cycles -> imem_addr stays 0x8 until ack, data dropped, then req at 0x80, delivered instr_pc 0x80.
- rst_n low during DROP, then PC near 0xFFFFFFFC -> all outputs return to reset values immediately, restart at RESET_PC; sequential fetch from 0xFFFFFFFC requests 0x00000000 next.
- FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_timeout rises in cycle 16, stays 1 after a later ack until reset; without macro stays 0.
